// File: rtl/neuron_readout_sequencer_if.sv
// Handshake and data bundle between the SPI front end / output mux and the
// readout sequencer.
interface neuron_readout_sequencer_if #(
    parameter int DW = 8
);
    logic          start;
    logic          abort;
    logic [7:0]    channel_mask;
    logic [2:0]    output_select;
    logic [DW-1:0] dout_spi;
    logic          shift_en;
    logic          sdo;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, channel_mask, dout_spi, shift_en,
        input  output_select, sdo, busy, done
    );

    modport slave (
        input  start, abort, channel_mask, dout_spi, shift_en,
        output output_select, sdo, busy, done
    );
endinterface

// File: rtl/neuron_readout_sequencer.sv
// Walks the set bits of a channel mask in ascending order, selecting each
// channel on the output mux and shifting its word out MSB first on shift_en.
module neuron_readout_sequencer #(
    parameter int DW = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    neuron_readout_sequencer_if.slave     bus
);
    localparam int CW = $clog2(DW);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        LOAD   = 3'd2,
        SHIFT  = 3'd3,
        NEXT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t        r_state;
    logic [7:0]    r_mask;
    logic [2:0]    r_sel;
    logic [DW-1:0] r_shreg;
    logic [CW-1:0] r_cnt;
    logic          r_done;

    state_t        w_state_nxt;
    logic [7:0]    w_mask_nxt;
    logic [2:0]    w_sel_nxt;
    logic [DW-1:0] w_shreg_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_done_nxt;

    logic          w_first_hit;
    logic [2:0]    w_first_idx;
    logic          w_next_hit;
    logic [2:0]    w_next_idx;

    // Priority search from the top down so the lowest qualifying index wins.
    always_comb begin
        w_first_hit = 1'b0;
        w_first_idx = 3'd0;
        w_next_hit  = 1'b0;
        w_next_idx  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bus.channel_mask[i]) begin
                w_first_hit = 1'b1;
                w_first_idx = 3'(i);
            end
            if (r_mask[i] && (i > int'(r_sel))) begin
                w_next_hit = 1'b1;
                w_next_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mask  <= '0;
            r_sel   <= '0;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_sel   <= w_sel_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_sel_nxt   = r_sel;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_mask_nxt = bus.channel_mask;
                    if (w_first_hit) begin
                        w_sel_nxt   = w_first_idx;
                        w_state_nxt = SELECT;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            SELECT: w_state_nxt = LOAD;
            LOAD: begin
                w_shreg_nxt = bus.dout_spi;
                w_cnt_nxt   = '0;
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (bus.shift_en) begin
                    w_shreg_nxt = {r_shreg[DW-2:0], 1'b0};
                    w_cnt_nxt   = r_cnt + 1'b1;
                    if (r_cnt == CW'(DW-1))
                        w_state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (w_next_hit) begin
                    w_sel_nxt   = w_next_idx;
                    w_state_nxt = SELECT;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // done is registered, so the pulse lands in the cycle after DONE
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (bus.abort && (r_state != IDLE)) begin
            w_state_nxt = IDLE;
            w_shreg_nxt = '0;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b0;
        end
    end

    assign bus.output_select = r_sel;
    assign bus.sdo           = (r_state == SHIFT) ? r_shreg[DW-1] : 1'b0;
    assign bus.busy          = (r_state != IDLE) && (r_state != DONE);
    assign bus.done          = r_done;
endmodule

// File: tb/tb_neuron_readout_sequencer.sv
// Directed bench for the readout sequencer: full, sparse, empty, abort,
// ignored-input and mid-frame reset scenarios.
module tb_neuron_readout_sequencer;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [7:0] mem [8];

    neuron_readout_sequencer_if #(.DW(8)) bif ();

    neuron_readout_sequencer #(.DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // External 8:1 mux returning the selected neuron word.
    always_comb bif.dout_spi = mem[bif.output_select];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input int n, output logic [7:0] b);
        b = '0;
        for (int i = 0; i < n; i++) begin
            b = {b[6:0], bif.sdo};
            bif.shift_en = 1'b1;
            tick();
            bif.shift_en = 1'b0;
        end
    endtask

    // Starts a frame in the current cycle and walks it to the done pulse.
    task automatic run_frame(input logic [7:0] mask, input bit noisy, input string tag);
        int         chs[$];
        logic [7:0] b;
        for (int i = 0; i < 8; i++) if (mask[i]) chs.push_back(i);
        bif.start = 1'b1;
        bif.channel_mask = mask;
        tick();
        bif.start = 1'b0;
        bif.channel_mask = ~mask;
        foreach (chs[k]) begin
            checks++;
            if (bif.output_select !== 3'(chs[k]) || bif.busy !== 1'b1 || bif.sdo !== 1'b0) begin
                errors++;
                $display("FAIL %s select ch%0d: sel=%0d busy=%b sdo=%b, want sel=%0d busy=1 sdo=0",
                         tag, chs[k], bif.output_select, bif.busy, bif.sdo, chs[k]);
            end
            bif.shift_en = noisy;
            bif.start = noisy;
            tick();
            bif.start = 1'b0;
            tick();
            bif.shift_en = 1'b0;
            shift_bits(8, b);
            checks++;
            if (b !== mem[chs[k]]) begin
                errors++;
                $display("FAIL %s data ch%0d: got %h, want %h", tag, chs[k], b, mem[chs[k]]);
            end
            checks++;
            if (bif.sdo !== 1'b0 || bif.busy !== 1'b1 || bif.done !== 1'b0) begin
                errors++;
                $display("FAIL %s next ch%0d: sdo=%b busy=%b done=%b, want 0 1 0",
                         tag, chs[k], bif.sdo, bif.busy, bif.done);
            end
            bif.shift_en = noisy;
            tick();
            bif.shift_en = 1'b0;
        end
        checks++;
        if (bif.busy !== 1'b0 || bif.done !== 1'b0) begin
            errors++;
            $display("FAIL %s done-state: busy=%b done=%b, want 0 0", tag, bif.busy, bif.done);
        end
        bif.start = noisy;
        tick();
        bif.start = 1'b0;
        checks++;
        if (bif.done !== 1'b1 || bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done pulse: done=%b busy=%b, want 1 0", tag, bif.done, bif.busy);
        end
        tick();
        checks++;
        if (bif.done !== 1'b0 || bif.busy !== 1'b0 || bif.output_select !== 3'(chs[chs.size()-1])) begin
            errors++;
            $display("FAIL %s after done: done=%b busy=%b sel=%0d, want 0 0 %0d",
                     tag, bif.done, bif.busy, bif.output_select, chs[chs.size()-1]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bif.output_select !== 3'd0 || bif.sdo !== 1'b0 || bif.busy !== 1'b0 || bif.done !== 1'b0) begin
            errors++;
            $display("FAIL reset: sel=%0d sdo=%b busy=%b done=%b, want 0 0 0 0",
                     bif.output_select, bif.sdo, bif.busy, bif.done);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_frame();
        for (int n = 0; n < 8; n++) mem[n] = 8'hA0 + 8'(n);
        run_frame(8'hFF, 1'b0, "full");
    endtask

    task automatic test_sparse();
        mem[0] = 8'h3C;
        mem[7] = 8'hC3;
        run_frame(8'h81, 1'b0, "sparse");
    endtask

    task automatic test_empty();
        logic [2:0] sel_before;
        sel_before = bif.output_select;
        bif.start = 1'b1;
        bif.channel_mask = 8'h00;
        tick();
        bif.start = 1'b0;
        checks++;
        if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.sdo !== 1'b0) begin
            errors++;
            $display("FAIL empty +1: busy=%b done=%b sdo=%b, want 0 0 0", bif.busy, bif.done, bif.sdo);
        end
        tick();
        checks++;
        if (bif.done !== 1'b1 || bif.busy !== 1'b0 || bif.output_select !== sel_before) begin
            errors++;
            $display("FAIL empty +2: done=%b busy=%b sel=%0d, want 1 0 %0d",
                     bif.done, bif.busy, bif.output_select, sel_before);
        end
        tick();
        checks++;
        if (bif.done !== 1'b0) begin
            errors++;
            $display("FAIL empty +3: done=%b, want 0", bif.done);
        end
    endtask

    task automatic test_abort();
        logic [7:0] b;
        for (int n = 0; n < 8; n++) mem[n] = 8'hA0 + 8'(n);
        bif.start = 1'b1;
        bif.channel_mask = 8'h0F;
        tick();
        bif.start = 1'b0;
        tick();
        tick();
        shift_bits(8, b);
        tick();
        tick();
        tick();
        checks++;
        if (bif.output_select !== 3'd1) begin
            errors++;
            $display("FAIL abort sel: got %0d, want 1", bif.output_select);
        end
        shift_bits(3, b);
        checks++;
        if (b[2:0] !== 3'b101) begin
            errors++;
            $display("FAIL abort bits: got %b, want 101", b[2:0]);
        end
        bif.abort = 1'b1;
        bif.shift_en = 1'b1;
        tick();
        bif.abort = 1'b0;
        bif.shift_en = 1'b0;
        checks++;
        if (bif.busy !== 1'b0 || bif.sdo !== 1'b0 || bif.done !== 1'b0) begin
            errors++;
            $display("FAIL abort idle: busy=%b sdo=%b done=%b, want 0 0 0", bif.busy, bif.sdo, bif.done);
        end
        tick();
        checks++;
        if (bif.done !== 1'b0 || bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort no-done: done=%b busy=%b, want 0 0", bif.done, bif.busy);
        end
        run_frame(8'h02, 1'b0, "post-abort");
    endtask

    task automatic test_abort_start_idle();
        bif.start = 1'b1;
        bif.abort = 1'b1;
        bif.channel_mask = 8'hFF;
        tick();
        bif.start = 1'b0;
        bif.abort = 1'b0;
        checks++;
        if (bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort+start: busy=%b, want 0", bif.busy);
        end
        tick();
        checks++;
        if (bif.done !== 1'b0 || bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort+start later: done=%b busy=%b, want 0 0", bif.done, bif.busy);
        end
    endtask

    task automatic test_ignored_inputs();
        for (int n = 0; n < 8; n++) mem[n] = 8'hA0 + 8'(n);
        run_frame(8'hFF, 1'b1, "noisy");
        tick();
        checks++;
        if (bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL noisy start-in-done: busy=%b, want 0", bif.busy);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [7:0] b;
        bif.start = 1'b1;
        bif.channel_mask = 8'hFF;
        tick();
        bif.start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            tick();
            shift_bits(8, b);
            tick();
        end
        tick();
        tick();
        checks++;
        if (bif.output_select !== 3'd2 || bif.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst-mid reach ch2: sel=%0d busy=%b, want 2 1", bif.output_select, bif.busy);
        end
        shift_bits(4, b);
        rst = 1'b1;
        bif.start = 1'b1;
        bif.shift_en = 1'b1;
        tick();
        bif.start = 1'b0;
        bif.shift_en = 1'b0;
        checks++;
        if (bif.output_select !== 3'd0 || bif.sdo !== 1'b0 || bif.busy !== 1'b0 || bif.done !== 1'b0) begin
            errors++;
            $display("FAIL rst-mid: sel=%0d sdo=%b busy=%b done=%b, want 0 0 0 0",
                     bif.output_select, bif.sdo, bif.busy, bif.done);
        end
        rst = 1'b0;
        mem[2] = 8'h5A;
        run_frame(8'h04, 1'b0, "post-rst");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int n = 0; n < 8; n++) mem[n] = 8'h00;
        rst = 1'b1;
        bif.start = 1'b0;
        bif.abort = 1'b0;
        bif.shift_en = 1'b0;
        bif.channel_mask = 8'h00;
        #1;
        test_reset();
        test_full_frame();
        test_sparse();
        test_empty();
        test_abort();
        test_abort_start_idle();
        test_ignored_inputs();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
